// File: rtl/bit_stuffer.sv
// rtl/bit_stuffer.sv - USB transmit bit stuffer: inserts a 0 after every MAX_RUN consecutive 1s.
// Sits between the CRC stage (held via pause) and the NRZI encoder; all stream outputs registered.
module bit_stuffer #(
  parameter int MAX_RUN = 6,
  localparam int CW = $clog2(MAX_RUN + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_in,
  input  logic start_b,
  input  logic endb,
  output logic pause,
  output logic s_out,
  output logic start_n,
  output logic end_n,
  output logic tx_active
);

  typedef enum logic [1:0] {IDLE, SEND, STUFF, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   run_q, run_d;
  logic            first_q, first_d;
  logic            s_out_q, s_out_d;
  logic            start_n_q, start_n_d;
  logic            end_n_q, end_n_d;
  logic            tx_active_q, tx_active_d;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    first_d     = first_q;
    s_out_d     = s_out_q;
    start_n_d   = 1'b0;
    end_n_d     = 1'b0;
    tx_active_d = tx_active_q;
    case (state_q)
      IDLE: begin
        s_out_d     = 1'b1;
        tx_active_d = 1'b0;
        if (start_b) begin
          state_d = SEND;
          run_d   = '0;
          first_d = 1'b1;
        end
      end
      SEND: begin
        first_d = 1'b0;
        if (endb) begin
          // An empty packet lands here on its first cycle: end_n without start_n.
          s_out_d     = 1'b1;
          tx_active_d = 1'b0;
          end_n_d     = 1'b1;
          state_d     = IDLE;
        end else begin
          s_out_d     = s_in;
          tx_active_d = 1'b1;
          start_n_d   = first_q;
          run_d       = s_in ? run_q + CW'(1) : '0;
          if (s_in && run_q == CW'(MAX_RUN - 1)) begin
            state_d = STUFF;
          end
        end
      end
      STUFF: begin
        s_out_d     = 1'b0;
        run_d       = '0;
        tx_active_d = 1'b1;
        // endb during the stuff cycle still lets the inserted 0 go out before closing.
        state_d     = endb ? FLUSH : SEND;
      end
      FLUSH: begin
        s_out_d     = 1'b1;
        tx_active_d = 1'b0;
        end_n_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_q       <= '0;
      first_q     <= 1'b0;
      s_out_q     <= 1'b1;
      start_n_q   <= 1'b0;
      end_n_q     <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      first_q     <= first_d;
      s_out_q     <= s_out_d;
      start_n_q   <= start_n_d;
      end_n_q     <= end_n_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign pause     = (state_q == STUFF);
  assign s_out     = s_out_q;
  assign start_n   = start_n_q;
  assign end_n     = end_n_q;
  assign tx_active = tx_active_q;

endmodule

// File: tb/tb_bit_stuffer.sv
// tb/tb_bit_stuffer.sv - self-checking bench for bit_stuffer against a queue-based stuffing model.
module tb_bit_stuffer;
  localparam int MAX_RUN = 6;
  typedef bit bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_in = 1'b0;
  logic start_b = 1'b0;
  logic endb = 1'b0;
  logic pause, s_out, start_n, end_n, tx_active;

  int checks = 0;
  int errors = 0;

  bq_t r_sout, r_tx, r_sn, r_en, r_p;
  bq_t got;
  int first_tx, last_tx, sn_cnt, sn_idx, en_cnt, en_idx, p_cnt, p_bad;

  bit_stuffer #(.MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .start_b(start_b), .endb(endb),
    .pause(pause), .s_out(s_out), .start_n(start_n), .end_n(end_n), .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  // Reference: walk the payload, emit each bit, and append a 0 whenever MAX_RUN 1s have accumulated.
  function automatic bq_t stuff_model(input bq_t b);
    bq_t o;
    int ones = 0;
    foreach (b[i]) begin
      o.push_back(b[i]);
      ones = b[i] ? ones + 1 : 0;
      if (ones == MAX_RUN) begin
        o.push_back(1'b0);
        ones = 0;
      end
    end
    return o;
  endfunction

  function automatic int count_stuffs(input bq_t b);
    return stuff_model(b).size() - b.size();
  endfunction

  function automatic logic [63:0] pack(input bq_t q);
    logic [63:0] v = '0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  function automatic bq_t ones_q(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic sample();
    r_sout.push_back(s_out);
    r_tx.push_back(tx_active);
    r_sn.push_back(start_n);
    r_en.push_back(end_n);
    r_p.push_back(pause);
  endtask

  // Acts as the CRC stage: presents bits, holds while pause is high, then raises endb.
  // Index k of the recorded queues is the k-th falling edge after start_b was presented.
  task automatic drive_packet(input bq_t bits, input int mid_start);
    int idx = 0;
    int cyc = 0;
    int tail = 0;
    bit done = 1'b0;
    r_sout.delete(); r_tx.delete(); r_sn.delete(); r_en.delete(); r_p.delete();
    @(negedge clk);
    sample();
    start_b = 1'b1; s_in = 1'b0; endb = 1'b0;
    @(negedge clk);
    start_b = 1'b0;
    while (tail < 3 && cyc < 300) begin
      sample();
      start_b = (cyc == mid_start);
      if (done) begin
        endb = 1'b0;
        tail++;
      end else if (idx < bits.size()) begin
        s_in = bits[idx];
        endb = 1'b0;
        if (!pause) idx++;
      end else begin
        s_in = 1'b0;
        endb = 1'b1;
        if (!pause) done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start_b = 1'b0; endb = 1'b0;
    checks++;
    if (cyc >= 300) begin
      errors++;
      $display("FAIL drive_timeout: cycles=%0d limit=300", cyc);
    end
    got.delete();
    first_tx = -1; last_tx = -1; sn_cnt = 0; sn_idx = -1; en_cnt = 0; en_idx = -1; p_cnt = 0; p_bad = 0;
    for (int k = 0; k < r_sout.size(); k++) begin
      if (r_tx[k]) begin
        got.push_back(r_sout[k]);
        if (first_tx < 0) first_tx = k;
        last_tx = k;
      end
      if (r_sn[k]) begin sn_cnt++; sn_idx = k; end
      if (r_en[k]) begin en_cnt++; en_idx = k; end
      if (r_p[k]) begin
        p_cnt++;
        if (!(r_tx[k] && r_sout[k] && (k + 1 < r_sout.size()) && !r_sout[k+1])) p_bad++;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({s_out, start_n, end_n, tx_active, pause} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_idle: got=%b exp=10000", {s_out, start_n, end_n, tx_active, pause});
    end
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0; s_in = 1'b1;
    @(negedge clk); s_in = 1'b0;
    @(negedge clk); s_in = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_out, start_n, end_n, tx_active, pause} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid_packet: got=%b exp=10000", {s_out, start_n, end_n, tx_active, pause});
    end
    @(negedge clk); rst_n = 1'b1; s_in = 1'b0;
    drive_packet('{1, 0, 1, 1}, -1);
    checks++;
    if (got.size() != 4 || pack(got) != pack('{1, 0, 1, 1}) || sn_cnt != 1 || en_cnt != 1) begin
      errors++;
      $display("FAIL reset_recover: got=%h/%0d sn=%0d en=%0d exp=%h/4 sn=1 en=1",
               pack(got), got.size(), sn_cnt, en_cnt, pack('{1, 0, 1, 1}));
    end
  endtask

  task automatic test_basic();
    drive_packet('{0, 1, 0, 1}, -1);
    checks++;
    if (got.size() != 4 || pack(got) != pack('{0, 1, 0, 1})) begin
      errors++;
      $display("FAIL basic_bits: got=%h/%0d exp=%h/4", pack(got), got.size(), pack('{0, 1, 0, 1}));
    end
    checks++;
    if (first_tx != 2 || sn_idx != 2 || sn_cnt != 1) begin
      errors++;
      $display("FAIL basic_start: first=%0d sn_idx=%0d sn_cnt=%0d exp=2,2,1", first_tx, sn_idx, sn_cnt);
    end
    checks++;
    if (p_cnt != 0 || en_idx != 6 || en_cnt != 1) begin
      errors++;
      $display("FAIL basic_end: pause=%0d en_idx=%0d en_cnt=%0d exp=0,6,1", p_cnt, en_idx, en_cnt);
    end
  endtask

  task automatic test_stuff(input string name, input bq_t bits);
    bq_t exp = stuff_model(bits);
    drive_packet(bits, -1);
    checks++;
    if (got.size() != exp.size() || pack(got) != pack(exp)) begin
      errors++;
      $display("FAIL %s_bits: got=%h/%0d exp=%h/%0d", name, pack(got), got.size(), pack(exp), exp.size());
    end
    checks++;
    if (p_cnt != count_stuffs(bits) || p_bad != 0) begin
      errors++;
      $display("FAIL %s_pause: got=%0d bad=%0d exp=%0d bad=0", name, p_cnt, p_bad, count_stuffs(bits));
    end
    checks++;
    if (en_cnt != 1 || en_idx != last_tx + 1 || sn_idx != first_tx) begin
      errors++;
      $display("FAIL %s_frame: en_cnt=%0d en_idx=%0d last=%0d sn_idx=%0d first=%0d", name, en_cnt, en_idx, last_tx, sn_idx, first_tx);
    end
  endtask

  task automatic test_empty();
    drive_packet('{}, -1);
    checks++;
    if (sn_cnt != 0 || got.size() != 0) begin
      errors++;
      $display("FAIL empty_start: sn_cnt=%0d bits=%0d exp=0,0", sn_cnt, got.size());
    end
    checks++;
    if (en_cnt != 1 || en_idx != 2) begin
      errors++;
      $display("FAIL empty_end: en_cnt=%0d en_idx=%0d exp=1,2", en_cnt, en_idx);
    end
  endtask

  task automatic test_start_in_send();
    bq_t bits = ones_q(8);
    bq_t exp = stuff_model(bits);
    drive_packet(bits, 2);
    checks++;
    if (pack(got) != pack(exp) || got.size() != exp.size() || sn_cnt != 1 || p_cnt != 1) begin
      errors++;
      $display("FAIL start_in_send: got=%h/%0d sn=%0d p=%0d exp=%h/%0d sn=1 p=1",
               pack(got), got.size(), sn_cnt, p_cnt, pack(exp), exp.size());
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 10; p++) begin
      bq_t bits;
      bq_t exp;
      int n = $urandom_range(0, 30);
      for (int i = 0; i < n; i++) bits.push_back($urandom_range(0, 3) != 0);
      exp = stuff_model(bits);
      drive_packet(bits, (p % 3 == 0) ? 1 : -1);
      checks++;
      if (got.size() != exp.size() || pack(got) != pack(exp)) begin
        errors++;
        $display("FAIL rand%0d_bits: got=%h/%0d exp=%h/%0d", p, pack(got), got.size(), pack(exp), exp.size());
      end
      checks++;
      if (p_cnt != count_stuffs(bits) || p_bad != 0 || en_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_ctrl: pause=%0d bad=%0d en=%0d exp=%0d,0,1", p, p_cnt, p_bad, en_cnt, count_stuffs(bits));
      end
      checks++;
      if (n > 0 && (sn_cnt != 1 || sn_idx != 2 || first_tx != 2 || en_idx != last_tx + 1)) begin
        errors++;
        $display("FAIL rand%0d_frame: sn=%0d sn_idx=%0d first=%0d en_idx=%0d last=%0d", p, sn_cnt, sn_idx, first_tx, en_idx, last_tx);
      end else if (n == 0 && (sn_cnt != 0 || en_idx != 2)) begin
        errors++;
        $display("FAIL rand%0d_empty: sn=%0d en_idx=%0d exp=0,2", p, sn_cnt, en_idx);
      end
    end
  endtask

  initial begin
    bq_t split;
    split = ones_q(5);
    split.push_back(1'b0);
    for (int i = 0; i < 6; i++) split.push_back(1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_stuff("eight_ones", ones_q(8));
    test_stuff("twelve_ones", ones_q(12));
    test_stuff("endb_in_stuff", ones_q(6));
    test_stuff("split_runs", split);
    test_empty();
    test_start_in_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
